// File: rtl/nic_pkg.sv
// Shared constants for the network interface controller: data width, PE register map
// and packet field positions.
package nic_pkg;

    localparam int unsigned DATA_WIDTH = 64;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    localparam int unsigned VC_BIT  = 63;
    localparam int unsigned DIR_MSB = 62;
    localparam int unsigned DIR_LSB = 61;
    localparam int unsigned HOP_MSB = 55;
    localparam int unsigned HOP_LSB = 48;
    localparam int unsigned SRC_MSB = 47;
    localparam int unsigned SRC_LSB = 32;

endpackage

// File: rtl/nic_buf.sv
// One-entry packet register with a full flag. A write strobe loads data and sets full;
// a read strobe clears full. The caller gates wr with ~full.
module nic_buf
    import nic_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // A write in the same cycle as a read wins, so a freshly captured packet is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (rd) begin
                full <= 1'b0;
            end
            if (wr) begin
                data <= wr_data;
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nic.sv
// NIC between a PE and the router PE port: PE register decode plus the polarity-matched
// injection and ready/strobe ejection handshakes around two one-entry buffers.
module nic
    import nic_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_ro,
    input  logic                  net_si,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_ri,
    input  logic                  net_polarity
);

    logic                  pe_rd;
    logic                  pe_wr;
    logic                  out_wr;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  in_wr;
    logic                  in_rd;
    logic                  in_full;
    logic [DATA_WIDTH-1:0] in_buf;

    assign pe_rd  = nicEn & ~nicWrEn;
    assign pe_wr  = nicEn & nicWrEn;
    assign out_wr = pe_wr & (addr == ADDR_OUT_BUF) & ~out_full;
    assign in_rd  = pe_rd & (addr == ADDR_IN_BUF);

    // The packet's VC bit selects which router polarity phase may accept it.
    assign net_so = out_full & net_ro & (net_polarity == out_buf[VC_BIT]);
    assign net_do = out_full ? out_buf : '0;
    assign net_ri = ~in_full;
    assign in_wr  = net_si & net_ri;

    nic_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .wr      (out_wr),
        .wr_data (d_in),
        .rd      (net_so),
        .data    (out_buf),
        .full    (out_full)
    );

    nic_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .wr      (in_wr),
        .wr_data (net_di),
        .rd      (in_rd),
        .data    (in_buf),
        .full    (in_full)
    );

    always_comb begin
        d_out = '0;
        if (pe_rd) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_buf;
                ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out = '0;
            endcase
        end
    end

endmodule

// File: doc/nic.md
# nic

Network interface controller between a processing element (PE) and the `router` PE port. Holds one outbound packet written by the PE and injects it into the router's PE input channel on the matching polarity phase. Accepts one inbound packet from the router's PE output channel and exposes it to the PE through a 2-bit register map with empty/full status.

## Interface
- `DATA_WIDTH`, 64, packet width; bit 63 is the VC bit, 62:61 direction, 55:48 hop count, 47:32 source, 31:0 payload.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `addr` input 2: PE register select. 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- `d_in` input DATA_WIDTH: PE write data.
- `d_out` output DATA_WIDTH: PE read data.
- `nicEn` input 1: PE access enable.
- `nicWrEn` input 1: 1 = write, 0 = read; only meaningful with `nicEn`.
- `net_so` output 1: send strobe to the router (router `pesi`).
- `net_do` output DATA_WIDTH: packet to the router (router `pedi`).
- `net_ro` input 1: router ready (router `peri`).
- `net_si` input 1: send strobe from the router (router `peso`).
- `net_di` input DATA_WIDTH: packet from the router (router `pedo`).
- `net_ri` output 1: NIC ready to accept (router `pero`).
- `net_polarity` input 1: router polarity; toggles every cycle.

## Operation
- State: `out_buf`/`out_full` (PE→net) and `in_buf`/`in_full` (net→PE).
- PE write, addr 10: if `nicEn & nicWrEn & ~out_full`, then at the edge `out_buf <= d_in` and `out_full <= 1`. A write while full is dropped with no state change.
- PE writes to addr 00, 01, 11 are ignored.
- PE read (`nicEn & ~nicWrEn`), combinational `d_out`:
  - addr 00: `in_buf`; at the edge `in_full <= 0`.
  - addr 01: `{63'b0, in_full}`.
  - addr 10: 0.
  - addr 11: `{63'b0, out_full}`.
- `d_out` = 0 when `nicEn = 0` or during a write.
- Injection:
  - `net_so = out_full & net_ro & (net_polarity == out_buf[63])`.
  - `net_do = out_buf`, driven continuously; drives 0 when `out_full = 0`.
  - At the edge where `net_so = 1`, `out_full <= 0`.
- Ejection:
  - `net_ri = ~in_full`.
  - If `net_si & net_ri`, at the edge `in_buf <= net_di` and `in_full <= 1`.
  - `net_si` while `in_full = 1` is a protocol violation; the data is not captured.

## Timing
- Reset values:
  - `out_full`, `in_full`, `out_buf`, `in_buf` = 0.
  - `net_so` = 0.
  - `net_ri` = 1.
  - `net_do` = 0.
  - `d_out` = 0.
- PE write to `net_so`: earliest one cycle later. The packet waits while `net_ro` = 0 or the polarity mismatches, so at most one extra cycle when `net_ro` = 1.
- Router capture to PE visibility: status reads 1 in the cycle after `net_si`. `net_ri` falls the same cycle.
- Input buffer read: status reads 0 and `net_ri` = 1 in the next cycle, so back-to-back ejection is possible every 2 cycles.
- PE write to addr 10 in the same cycle as injection: the write is dropped because `out_full` = 1 at sample time. The PE must poll status.
- PE read of addr 00 while `in_full` = 0: returns the stale `in_buf`, and the flag stays 0.
- `reset` mid-transfer: a held packet is lost and `net_so` drops immediately (asynchronous).

## Structure
- Shared package `nic_pkg`:
  - `DATA_WIDTH`.
  - Address constants `ADDR_IN_BUF`, `ADDR_IN_STAT`, `ADDR_OUT_BUF`, `ADDR_OUT_STAT`.
  - Packet field positions: `VC_BIT` = 63, `DIR_MSB`/`DIR_LSB`, `HOP_MSB`/`HOP_LSB`, `SRC_MSB`/`SRC_LSB`.
- One sub-module `nic_buf`: a one-entry register with a full flag and `wr`/`rd` strobes. It is instantiated twice (outbound and inbound); `nic` holds the decode and handshake glue.

## Test plan
- Reset, then idle: `net_ri` = 1, `net_so` = 0, addr 01/11 read 0, `d_out` = 0 with `nicEn` = 0.
- Write addr 10 with 64'hC010_0000_1111_1111 while `net_ro` = 1. Required: `net_so` = 1 only in the cycle with `net_polarity` = 1, `net_do` equals the packet, and addr 11 reads 0 the next cycle.
- Write addr 10 while `net_ro` = 0 for 5 cycles. Required: `net_so` stays 0 and addr 11 = 1. A second write of 64'h0 is dropped; after `net_ro` rises, the first packet is sent.
- Router pulses `net_si` with 64'h4020_0005_DEAD_BEEF. Required: next cycle `net_ri` = 0 and addr 01 reads 1. Reading addr 00 returns DEAD_BEEF packet; the following cycle `net_ri` = 1.
- Injection and ejection in the same cycle. Required: both complete independently with no corruption of either buffer.
- Assert `reset` for 3 ns mid-cycle while `out_full` = 1. Required: `net_so` drops at once, and after release addr 11 reads 0.
